// File: rtl/tpu_pkg.sv
// Shared types and array geometry for the systolic array control blocks.
package tpu_pkg;

    localparam int ARRAY_ROWS         = 16;
    localparam int ARRAY_COLS         = 16;
    localparam int DATA_W             = 32;
    localparam int POS_W              = 8;
    localparam int DEF_STROBE_CYCLES  = 2;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADDR = 3'd1,
        STRB = 3'd2,
        CAP  = 3'd3,
        OUT  = 3'd4,
        DONE = 3'd5
    } drain_state_t;

endpackage

// File: rtl/rc_scan_counter.sv
// Row-major row/column scan counter; saturates on the final element instead of wrapping.
module rc_scan_counter
    import tpu_pkg::*;
#(
    parameter int ROWS = ARRAY_ROWS,
    parameter int COLS = ARRAY_COLS,
    parameter int PW   = POS_W
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          clear,
    input  logic          advance,
    output logic [PW-1:0] row,
    output logic [PW-1:0] col,
    output logic          last
);

    logic [PW-1:0] row_q, row_d;
    logic [PW-1:0] col_q, col_d;
    logic          row_end;
    logic          col_end;

    assign row_end = (row_q == PW'(ROWS - 1));
    assign col_end = (col_q == PW'(COLS - 1));

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clear) begin
            row_d = '0;
            col_d = '0;
        end else if (advance && !(row_end && col_end)) begin
            if (col_end) begin
                col_d = '0;
                row_d = row_q + PW'(1);
            end else begin
                col_d = col_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row  = row_q;
    assign col  = col_q;
    assign last = row_end && col_end;

endmodule

// File: rtl/pe_array_drain.sv
// Walks every PE of the systolic array in row-major order through its rdn read-out
// port and forwards each captured value on a valid/ready result stream.
module pe_array_drain
    import tpu_pkg::*;
#(
    parameter int ROWS          = ARRAY_ROWS,
    parameter int COLS          = ARRAY_COLS,
    parameter int DW            = DATA_W,
    parameter int PW            = POS_W,
    parameter int STROBE_CYCLES = DEF_STROBE_CYCLES
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic [PW-1:0] x_position,
    output logic [PW-1:0] y_position,
    output logic          rdn,
    input  logic [DW-1:0] rd_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [PW-1:0] out_row,
    output logic [PW-1:0] out_col,
    output logic          out_last
);

    localparam int SW = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;

    drain_state_t  state_q, state_d;
    logic [SW-1:0] strb_cnt_q, strb_cnt_d;

    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          rdn_q, rdn_d;
    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic [PW-1:0] out_row_q, out_row_d;
    logic [PW-1:0] out_col_q, out_col_d;
    logic          out_last_q, out_last_d;

    logic          cnt_clear;
    logic          cnt_advance;
    logic [PW-1:0] cur_row;
    logic [PW-1:0] cur_col;
    logic          cur_last;

    // The counter registers drive the array position directly, so the position only
    // moves on the handshake edge (into ADDR) while rdn is already high.
    rc_scan_counter #(
        .ROWS (ROWS),
        .COLS (COLS),
        .PW   (PW)
    ) u_scan (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (cnt_clear),
        .advance (cnt_advance),
        .row     (cur_row),
        .col     (cur_col),
        .last    (cur_last)
    );

    always_comb begin
        state_d     = state_q;
        strb_cnt_d  = strb_cnt_q;
        cnt_clear   = 1'b0;
        cnt_advance = 1'b0;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_row_d   = out_row_q;
        out_col_d   = out_col_q;
        out_last_d  = out_last_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = ADDR;
                    cnt_clear = 1'b1;
                end
            end
            ADDR: begin
                state_d    = STRB;
                strb_cnt_d = '0;
            end
            STRB: begin
                if (strb_cnt_q == SW'(STROBE_CYCLES - 1)) begin
                    state_d = CAP;
                end else begin
                    strb_cnt_d = strb_cnt_q + SW'(1);
                end
            end
            CAP: begin
                out_data_d  = rd_data;
                out_row_d   = cur_row;
                out_col_d   = cur_col;
                out_last_d  = cur_last;
                out_valid_d = 1'b1;
                state_d     = OUT;
            end
            OUT: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    if (cur_last) begin
                        state_d = DONE;
                    end else begin
                        cnt_advance = 1'b1;
                        state_d     = ADDR;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort overrides every transition, including a same-cycle start.
        if (abort) begin
            state_d     = IDLE;
            strb_cnt_d  = '0;
            cnt_clear   = 1'b1;
            cnt_advance = 1'b0;
            out_valid_d = 1'b0;
        end

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
        rdn_d  = (state_d != STRB);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            strb_cnt_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rdn_q       <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_row_q   <= '0;
            out_col_q   <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            strb_cnt_q  <= strb_cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rdn_q       <= rdn_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_row_q   <= out_row_d;
            out_col_q   <= out_col_d;
            out_last_q  <= out_last_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign rdn        = rdn_q;
    assign x_position = cur_row;
    assign y_position = cur_col;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_row    = out_row_q;
    assign out_col    = out_col_q;
    assign out_last   = out_last_q;

endmodule

// File: tb/tb_pe_array_drain.sv
// Self-checking bench for pe_array_drain: behavioural PE array, row-major reference
// sequence, table of drain scenarios plus abort/reset/restart corner sequences.
module tb_pe_array_drain;

    localparam int ROWS = 16;
    localparam int COLS = 16;
    localparam int DW   = 32;
    localparam int PW   = 8;
    localparam int NEL  = ROWS * COLS;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n;
    logic          start, abort, out_ready;
    logic [DW-1:0] rd_data;
    logic          busy, done, rdn, out_valid, out_last;
    logic [PW-1:0] x_position, y_position, out_row, out_col;
    logic [DW-1:0] out_data;

    logic          start2;
    logic [DW-1:0] rd_data2;
    logic          busy2, done2, rdn2, out_valid2, out_last2;
    logic [PW-1:0] x_position2, y_position2, out_row2, out_col2;
    logic [DW-1:0] out_data2;

    pe_array_drain dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .busy(busy), .done(done),
        .x_position(x_position), .y_position(y_position), .rdn(rdn), .rd_data(rd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_row(out_row), .out_col(out_col), .out_last(out_last)
    );

    pe_array_drain #(.STROBE_CYCLES(1)) dut_s1 (
        .clk(clk), .reset_n(reset_n), .start(start2), .abort(1'b0), .busy(busy2), .done(done2),
        .x_position(x_position2), .y_position(y_position2), .rdn(rdn2), .rd_data(rd_data2),
        .out_valid(out_valid2), .out_ready(1'b1), .out_data(out_data2),
        .out_row(out_row2), .out_col(out_col2), .out_last(out_last2)
    );

    int errors = 0;
    int checks = 0;
    logic [15:0] salt;

    function automatic logic [DW-1:0] pe_value(input int r, input int c);
        return {salt, 8'(r), 8'(c)};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural array: latches the addressed PE on the falling edge of rdn.
    always @(negedge rdn)  rd_data  = pe_value(int'(x_position),  int'(y_position));
    always @(negedge rdn2) rd_data2 = pe_value(int'(x_position2), int'(y_position2));

    int pcnt = 0;
    always @(posedge clk) pcnt <= pcnt + 1;

    int ready_mode = 0;
    int rphase = 0;
    always @(posedge clk) begin
        #1;
        rphase++;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = (rphase % 4 == 0);
            2:       out_ready = 1'(($urandom_range(0, 1)));
            default: out_ready = 1'b0;
        endcase
    end

    // Monitor of the default build: totals only grow; tasks keep baselines.
    bit            mon_on = 0;
    bit            disturb = 0;
    int            tot_elems = 0, tot_done = 0, done_pc = 0, low_run = 0;
    int            elem_base = 0, done_base = 0;
    logic          prev_rdn = 1'b1, prev_valid = 1'b0, prev_ready = 1'b0;
    logic [PW-1:0] prev_x = '0, prev_y = '0;
    logic [49:0]   prev_out = '0;

    always @(negedge clk) begin
        if (mon_on) begin
            int idx, r, c;
            if (!rdn) low_run++;
            else if (prev_rdn === 1'b0) begin
                if (!disturb) check("rdn_low_clocks", 64'(low_run), 64'd2);
                low_run = 0;
            end
            if (rdn !== prev_rdn && !disturb)
                check("pos_stable_at_rdn_edge", {x_position, y_position}, {prev_x, prev_y});
            if (prev_valid && !prev_ready && !disturb)
                check("stall_hold", {out_valid, out_row, out_col, out_last, out_data}, prev_out);
            if (out_valid && out_ready) begin
                idx = tot_elems - elem_base;
                r = idx / COLS;
                c = idx % COLS;
                check("elem", {out_row, out_col, out_last, out_data},
                      {8'(r), 8'(c), (idx == NEL - 1), pe_value(r, c)});
                tot_elems++;
            end
            if (done) begin
                tot_done++;
                done_pc = pcnt;
            end
            prev_rdn   = rdn;
            prev_x     = x_position;
            prev_y     = y_position;
            prev_valid = out_valid;
            prev_ready = out_ready;
            prev_out   = {1'b1, out_row, out_col, out_last, out_data};
        end
    end

    bit   mon2_on = 0;
    int   tot2_elems = 0, tot2_done = 0, done2_pc = 0, low2 = 0;
    logic prev_rdn2 = 1'b1;

    always @(negedge clk) begin
        if (mon2_on) begin
            int r, c;
            if (!rdn2) low2++;
            else if (prev_rdn2 === 1'b0) begin
                check("rdn_low_clocks_s1", 64'(low2), 64'd1);
                low2 = 0;
            end
            if (out_valid2) begin
                r = tot2_elems / COLS;
                c = tot2_elems % COLS;
                check("elem_s1", {out_row2, out_col2, out_last2, out_data2},
                      {8'(r), 8'(c), (tot2_elems == NEL - 1), pe_value(r, c)});
                tot2_elems++;
            end
            if (done2) begin
                tot2_done++;
                done2_pc = pcnt;
            end
            prev_rdn2 = rdn2;
        end
    end

    task automatic begin_drain(input int mode, output int spc);
        @(negedge clk);
        ready_mode = mode;
        elem_base  = tot_elems;
        done_base  = tot_done;
        disturb    = 0;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        spc   = pcnt;
    endtask

    task automatic finish_drain(input int spc, output int elems, output int dones, output int dur);
        int i;
        i = 0;
        while (tot_done == done_base && i < 20000) begin
            @(negedge clk);
            i++;
        end
        check("done_within_budget", 64'(tot_done != done_base), 64'd1);
        repeat (10) @(negedge clk);
        elems = tot_elems - elem_base;
        dones = tot_done - done_base;
        dur   = done_pc - spc;
    endtask

    typedef struct {
        int mode;
        int exp_elems;
        int exp_dones;
        int exp_clocks;
    } vec_t;

    vec_t tbl[3];

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int spc, elems, dones, dur, i;

        salt    = 16'($urandom);
        reset_n = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        start2  = 1'b0;

        tbl[0] = '{0, NEL, 1, 5 * NEL};
        tbl[1] = '{1, NEL, 1, -1};
        tbl[2] = '{2, NEL, 1, -1};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rdn", rdn, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_pos", {x_position, y_position}, 0);
        check("rst_out_fields", {out_data, out_row, out_col, out_last}, 0);
        check("rst_rdn_s1", rdn2, 1);
        reset_n = 1'b1;
        mon_on  = 1;
        repeat (2) @(negedge clk);

        // start and abort together while idle: stays idle
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        repeat (3) @(negedge clk);
        check("start_abort_idle_busy", busy, 0);
        check("start_abort_idle_rdn", rdn, 1);

        for (int v = 0; v < 3; v++) begin
            begin_drain(tbl[v].mode, spc);
            finish_drain(spc, elems, dones, dur);
            check($sformatf("tbl%0d_elems", v), 64'(elems), 64'(tbl[v].exp_elems));
            check($sformatf("tbl%0d_dones", v), 64'(dones), 64'(tbl[v].exp_dones));
            if (tbl[v].exp_clocks >= 0)
                check($sformatf("tbl%0d_clocks", v), 64'(dur), 64'(tbl[v].exp_clocks));
            check($sformatf("tbl%0d_busy_after", v), busy, 0);
        end

        // start again at element (3,7) is ignored
        begin_drain(0, spc);
        i = 0;
        while (!(x_position == 8'd3 && y_position == 8'd7) && i < 3000) begin
            @(negedge clk);
            i++;
        end
        check("reach_3_7", {x_position, y_position}, {8'd3, 8'd7});
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        finish_drain(spc, elems, dones, dur);
        check("restart_ign_elems", 64'(elems), 64'(NEL));
        check("restart_ign_dones", 64'(dones), 64'd1);
        check("restart_ign_clocks", 64'(dur), 64'(5 * NEL));

        // abort while rdn is low at element (5,2)
        begin_drain(0, spc);
        i = 0;
        @(negedge clk);
        while (!(x_position == 8'd5 && y_position == 8'd2 && rdn == 1'b0) && i < 3000) begin
            @(negedge clk);
            i++;
        end
        check("reach_5_2_strobe", {x_position, y_position, rdn}, {8'd5, 8'd2, 1'b0});
        #1;
        disturb = 1;
        abort   = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("abort_rdn", rdn, 1);
        check("abort_busy", busy, 0);
        check("abort_out_valid", out_valid, 0);
        check("abort_pos_cleared", {x_position, y_position}, 0);
        repeat (10) @(negedge clk);
        check("abort_no_done", 64'(tot_done - done_base), 0);
        check("abort_elems", 64'(tot_elems - elem_base), 64'(5 * COLS + 2));
        begin_drain(0, spc);
        finish_drain(spc, elems, dones, dur);
        check("after_abort_elems", 64'(elems), 64'(NEL));
        check("after_abort_clocks", 64'(dur), 64'(5 * NEL));

        // async reset during OUT of element (10,10)
        begin_drain(0, spc);
        i = 0;
        @(negedge clk);
        while (!(out_valid && out_row == 8'd10 && out_col == 8'd10) && i < 3000) begin
            @(negedge clk);
            i++;
        end
        check("reach_10_10_out", {out_valid, out_row, out_col}, {1'b1, 8'd10, 8'd10});
        #1;
        disturb = 1;
        reset_n = 1'b0;
        #1;
        check("areset_out_valid", out_valid, 0);
        check("areset_rdn", rdn, 1);
        check("areset_pos", {x_position, y_position}, 0);
        check("areset_busy_done", {busy, done}, 0);
        check("areset_out_fields", {out_data, out_row, out_col, out_last}, 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        check("post_reset_idle", {busy, rdn, out_valid}, 3'b010);
        check("reset_elems", 64'(tot_elems - elem_base), 64'(10 * COLS + 11));
        begin_drain(0, spc);
        finish_drain(spc, elems, dones, dur);
        check("after_reset_elems", 64'(elems), 64'(NEL));
        check("after_reset_clocks", 64'(dur), 64'(5 * NEL));

        // STROBE_CYCLES=1 build
        mon2_on = 1;
        @(negedge clk);
        start2 = 1'b1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        spc = pcnt;
        i = 0;
        while (tot2_done == 0 && i < 20000) begin
            @(negedge clk);
            i++;
        end
        repeat (10) @(negedge clk);
        check("s1_dones", 64'(tot2_done), 64'd1);
        check("s1_elems", 64'(tot2_elems), 64'(NEL));
        check("s1_clocks", 64'(done2_pc - spc), 64'(4 * NEL));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
